// File: rtl/qspi_master.sv
// ----------------------------------------------------------------------------
// qspi_master
//   Quad-SPI master for a serial SRAM running in quad (SQI) mode.
//   One byte per transfer: 2 command nibbles, 6 address nibbles, then either
//   2 write-data nibbles (driven) or DUMMY_NIBBLES turnaround nibbles followed
//   by 2 read-data nibbles (sampled). sck = clk/2, SPI mode 0.
//
//   Optional build macro: QSPI_MASTER_EQIO_EN
//     When defined, the master runs an INIT sequence after every reset that
//     shifts the "enter quad I/O" command (8'h38) out serially on sio_out[0]
//     before the first request is accepted. When undefined, the SRAM is
//     assumed to be in quad mode already and INIT is never entered.
//
//   All outputs are registered. The next value of every output is derived
//   from the next-state values, so an output always matches the state the
//   block is in during the same cycle.
// ----------------------------------------------------------------------------
module qspi_master #(
  parameter logic [7:0]  CMD_READ      = 8'h03,
  parameter logic [7:0]  CMD_WRITE     = 8'h02,
  parameter int unsigned DUMMY_NIBBLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        sck,
  output logic        ss_n,
  output logic [3:0]  sio_out,
  output logic [3:0]  sio_oe,
  input  logic [3:0]  sio_in
);

  // FSM state encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] DUMMY = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] INIT  = 3'd5;

  // Last nibble index inside the DUMMY state (only meaningful if DUMMY_NIBBLES > 0)
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIBBLES - 32'd1);
  localparam logic       HAS_DUMMY  = (DUMMY_NIBBLES != 32'd0);

  // Command that switches the SRAM from SPI to quad I/O
  localparam logic [7:0] EQIO_CMD = 8'h38;

  // --------------------------------------------------------------------------
  // Nibble selection helpers
  // --------------------------------------------------------------------------
  function automatic logic [3:0] byte_nib(input logic [7:0] b, input logic lo);
    byte_nib = lo ? b[3:0] : b[7:4];
  endfunction

  function automatic logic [3:0] addr_nib(input logic [23:0] a, input logic [3:0] idx);
    case (idx)
      4'd0:    addr_nib = a[23:20];
      4'd1:    addr_nib = a[19:16];
      4'd2:    addr_nib = a[15:12];
      4'd3:    addr_nib = a[11:8];
      4'd4:    addr_nib = a[7:4];
      4'd5:    addr_nib = a[3:0];
      default: addr_nib = 4'h0;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;        // nibble index inside the current state
  logic        phase_q, phase_d;    // 0: sck low / data change, 1: sck high
  logic        we_q, we_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rx_q, rx_d;          // read-data shift register

  // Registered outputs
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        sck_q, sck_d;
  logic        ss_n_q, ss_n_d;
  logic [3:0]  sio_out_q, sio_out_d;
  logic [3:0]  sio_oe_q, sio_oe_d;

  logic        last_s;              // current nibble is the last one of its state
  logic        init_pend_s;         // INIT sequence still owed after reset

`ifdef QSPI_MASTER_EQIO_EN
  logic        init_done_q, init_done_d;

  // INIT is owed until it has completed once since the last reset
  always_comb begin
    init_pend_s = ~init_done_q;
  end
`else
  // Without the quad-enable sequence there is never anything owed after reset
  always_comb begin
    init_pend_s = 1'b0;
  end
`endif

  // Flag the final nibble of each multi-nibble state
  always_comb begin
    last_s = 1'b0;
    case (state_q)
      CMD:     last_s = (cnt_q == 4'd1);
      ADDR:    last_s = (cnt_q == 4'd5);
      DUMMY:   last_s = (cnt_q == DUMMY_LAST);
      DATA:    last_s = (cnt_q == 4'd1);
      INIT:    last_s = (cnt_q == 4'd7);
      default: last_s = 1'b0;
    endcase
  end

  // Next-state, request capture and read-data assembly
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rx_d        = rx_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef QSPI_MASTER_EQIO_EN
    init_done_d = init_done_q;
`endif

    if (state_q == IDLE) begin
      if (init_pend_s) begin
        state_d = INIT;
        cnt_d   = 4'd0;
        phase_d = 1'b0;
      end else if (req_valid && req_ready_q) begin
        state_d = CMD;
        cnt_d   = 4'd0;
        phase_d = 1'b0;
        we_d    = req_we;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end else begin
        state_d = IDLE;
      end
    end else if (phase_q == 1'b0) begin
      // This edge raises sck: the SRAM's read nibble is sampled here
      phase_d = 1'b1;
      if ((state_q == DATA) && !we_q) begin
        rx_d = {rx_q[3:0], sio_in};
      end else begin
        rx_d = rx_q;
      end
    end else begin
      // This edge lowers sck and moves on to the next nibble
      phase_d = 1'b0;
      if (last_s) begin
        cnt_d = 4'd0;
        case (state_q)
          CMD:   state_d = ADDR;
          ADDR:  state_d = (we_q || !HAS_DUMMY) ? DATA : DUMMY;
          DUMMY: state_d = DATA;
          DATA: begin
            state_d = IDLE;
            if (!we_q) begin
              rsp_valid_d = 1'b1;
              rsp_rdata_d = rx_q;
            end else begin
              rsp_valid_d = 1'b0;
            end
          end
          INIT: begin
            state_d = IDLE;
`ifdef QSPI_MASTER_EQIO_EN
            init_done_d = 1'b1;
`endif
          end
          default: state_d = IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Pin values for the coming cycle, derived from the coming state
  always_comb begin
    ss_n_d      = 1'b1;
    sck_d       = 1'b0;
    sio_out_d   = 4'h0;
    sio_oe_d    = 4'h0;
    req_ready_d = 1'b0;
    case (state_d)
      IDLE: begin
        req_ready_d = 1'b1;
      end
      CMD: begin
        ss_n_d    = 1'b0;
        sck_d     = phase_d;
        sio_oe_d  = 4'hF;
        sio_out_d = byte_nib(we_d ? CMD_WRITE : CMD_READ, cnt_d[0]);
      end
      ADDR: begin
        ss_n_d    = 1'b0;
        sck_d     = phase_d;
        sio_oe_d  = 4'hF;
        sio_out_d = addr_nib(addr_d, cnt_d);
      end
      DUMMY: begin
        ss_n_d    = 1'b0;
        sck_d     = phase_d;
      end
      DATA: begin
        ss_n_d = 1'b0;
        sck_d  = phase_d;
        if (we_d) begin
          sio_oe_d  = 4'hF;
          sio_out_d = byte_nib(wdata_d, cnt_d[0]);
        end else begin
          sio_oe_d  = 4'h0;
          sio_out_d = 4'h0;
        end
      end
      INIT: begin
        ss_n_d    = 1'b0;
        sck_d     = phase_d;
        sio_oe_d  = 4'b0001;
        sio_out_d = {3'b000, EQIO_CMD[3'd7 - cnt_d[2:0]]};
      end
      default: begin
        ss_n_d = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      phase_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 24'h000000;
      wdata_q     <= 8'h00;
      rx_q        <= 8'h00;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      sck_q       <= 1'b0;
      ss_n_q      <= 1'b1;
      sio_out_q   <= 4'h0;
      sio_oe_q    <= 4'h0;
`ifdef QSPI_MASTER_EQIO_EN
      init_done_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rx_q        <= rx_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      sck_q       <= sck_d;
      ss_n_q      <= ss_n_d;
      sio_out_q   <= sio_out_d;
      sio_oe_q    <= sio_oe_d;
`ifdef QSPI_MASTER_EQIO_EN
      init_done_q <= init_done_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sck       = sck_q;
  assign ss_n      = ss_n_q;
  assign sio_out   = sio_out_q;
  assign sio_oe    = sio_oe_q;

endmodule

// File: doc/qspi_master.md
QSPI_MASTER -- requirements
Module: qspi_master

Interface
REQ-001 SHALL have parameter CMD_READ, default 8'h03, quad read command.
REQ-002 SHALL have parameter CMD_WRITE, default 8'h02, quad write command.
REQ-003 SHALL have parameter DUMMY_NIBBLES, default 2, turnaround nibbles between read address and read data.
REQ-004 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have ports req_valid/req_ready  in/out  1/1  request handshake, transfer when both high at a clk edge.
REQ-007 SHALL have ports req_we  in  1 (1=write) and req_addr  in  24  byte address.
REQ-008 SHALL have port req_wdata  in  8  write byte.
REQ-009 SHALL have ports rsp_valid  out  1 (one-cycle pulse) and rsp_rdata  out  8  read byte.
REQ-010 SHALL have ports sck  out  1 and ss_n  out  1  SRAM clock and select.
REQ-011 SHALL have ports sio_out  out  4, sio_oe  out  4 (per-bit drive enable) and sio_in  in  4  quad data lines.

Function
REQ-012 SHALL run sck at clk/2, SPI mode 0: each nibble = phase 0 (sck=0, sio_out updated) then phase 1 (sck=1).
REQ-013 SHALL sample sio_in on the clk edge that drives sck 0->1.
REQ-014 SHALL hold req_ready high only in IDLE; requests while busy are not accepted.
REQ-015 SHALL, on acceptance at edge T, register we/addr/wdata and drive ss_n=0 with first nibble from T+1.
REQ-016 SHALL send nibbles MSB first: command (2), address (6), then write data (2) with sio_oe=4'hF.
REQ-017 SHALL for reads send command+address with sio_oe=4'hF, then DUMMY_NIBBLES and 2 data nibbles with sio_oe=4'h0.
REQ-018 SHALL return to IDLE (ss_n=1, sck=0, sio_oe=0, req_ready=1) the cycle after the last phase 1: write T+21, read T+25 (defaults).
REQ-019 SHALL pulse rsp_valid with assembled rsp_rdata in that same first IDLE cycle for reads only; rsp_rdata holds until next read.
REQ-020 SHALL allow a request accepted in the first IDLE cycle, giving exactly one clk of ss_n high between transfers.
REQ-021 SHALL use states IDLE, CMD, ADDR, DUMMY, DATA (plus INIT when configured); nibble counter wraps per state.
REQ-022 SHALL keep sck=0 whenever ss_n=1.

Reset
REQ-023 SHALL, with rst_n low at an edge, force ss_n=1, sck=0, sio_out=0, sio_oe=0, rsp_valid=0, rsp_rdata=0, req_ready=0.
REQ-024 SHALL abort any transfer on reset mid-operation with no rsp_valid; ss_n high the cycle after.
REQ-025 SHALL reach IDLE with req_ready=1 the first cycle after rst_n returns high (macro undefined).

Configuration
REQ-026 SHALL, with QSPI_MASTER_EQIO_EN defined, enter INIT after reset: ss_n=0, sio_oe=4'b0001, send 8'h38 serially on sio_out[0] MSB first over 16 clks, sio_out[3:1]=0, then IDLE.
REQ-027 SHALL hold req_ready low during INIT; reset during INIT restarts INIT.
REQ-028 SHALL, without QSPI_MASTER_EQIO_EN, omit INIT entirely and assume the SRAM is already in quad mode.

Verification
REQ-029 Write addr 24'h012345 data 8'hA5 -> nibbles 0,2,0,1,2,3,4,5,A,5 on sck rises, ss_n low 20 clks, req_ready back at T+21.
REQ-030 Read addr 24'hABCDEF with SRAM model holding 8'h3C -> sio_oe=0 for last 4 nibbles, rsp_valid one pulse at T+25, rsp_rdata=8'h3C.
REQ-031 Back-to-back write then read with req_valid held -> second accepted at T+21, ss_n high exactly 1 clk.
REQ-032 rst_n low at cycle 7 of a read -> ss_n=1 next cycle, no rsp_valid, next read returns correct data.
REQ-033 req_valid asserted during a transfer -> not accepted until IDLE; accepted request data unchanged.
REQ-034 QSPI_MASTER_EQIO_EN defined -> sio_out[0] bits 0,0,1,1,1,0,0,0 on 8 sck rises, req_ready high 17 clks after reset release.
